opl_timer_bank: RTL and testbench

OPL_TIMER_BANK -- requirements
Module: opl_timer_bank

---
 rtl/opl_timer_bank.sv | 146 ++++++++++++++
 tb/tb_opl_timer_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/opl_timer_bank.sv
// rtl/opl_timer_bank.sv - OPL-style prescaled timer bank with flags/IRQ; optional poll detect under OPL_TIMER_POLL_FORCE_EN
module opl_timer_bank #(
    parameter int NTIMERS     = 2,
    parameter int RES_BASE    = 79,
    parameter int PRESET_BASE = 2,
    parameter int CTRL_INDEX  = 4,
    parameter int POLL_COUNT  = 21,
    parameter int POLL_WINDOW = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce_1us,
    input  logic               wr,
    input  logic [8:0]         wr_index,
    input  logic [7:0]         wr_data,
    input  logic               status_rd,
    output logic [7:0]         status,
    output logic               irq_n,
    output logic [NTIMERS-1:0] timer_pulse
);

    logic [7:0]         preset [NTIMERS];
    logic [NTIMERS-1:0] mask;
    logic [NTIMERS-1:0] start;
    logic [NTIMERS-1:0] flag;
    logic [NTIMERS-1:0] wrap;
    logic [NTIMERS-1:0] poll_set;
    logic [NTIMERS-1:0] flag_set;
    logic [2:0]         flag3;
    logic               ctrl_wr;
    logic               flag_clear;

    assign ctrl_wr    = wr && (wr_index == 9'(CTRL_INDEX));
    assign flag_clear = ctrl_wr && wr_data[7];

    // Register file: presets, plus mask/start from non-clearing control writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NTIMERS; i++) begin
                preset[i] <= 8'd0;
            end
            mask  <= '0;
            start <= '0;
        end else begin
            for (int i = 0; i < NTIMERS; i++) begin
                if (wr && (wr_index == 9'(PRESET_BASE + i))) begin
                    preset[i] <= wr_data;
                end
                if (ctrl_wr && !wr_data[7]) begin
                    mask[i]  <= wr_data[6 - i];
                    start[i] <= wr_data[i];
                end
            end
        end
    end

    for (genvar i = 0; i < NTIMERS; i++) begin : g_timer
        // Each timer's prescaler is four times longer than the previous one
        localparam logic [31:0] RELOAD = 32'(((RES_BASE + 1) << (2 * i)) - 1);

        logic [7:0]  counter;
        logic [31:0] prescaler;

        assign wrap[i] = start[i] && ce_1us && (prescaler == 32'd0) && (counter == 8'hFF);

        // Stopped timers shadow the preset, so a start always begins from it
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                counter   <= 8'd0;
                prescaler <= RELOAD;
            end else if (!start[i]) begin
                counter   <= preset[i];
                prescaler <= RELOAD;
            end else if (ce_1us) begin
                if (prescaler == 32'd0) begin
                    prescaler <= RELOAD;
                    counter   <= (counter == 8'hFF) ? preset[i] : counter + 8'd1;
                end else begin
                    prescaler <= prescaler - 32'd1;
                end
            end
        end
    end

    assign flag_set = (wrap & ~mask) | poll_set;

    // Overflow pulses and sticky flags; a set in the same cycle beats a clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag        <= '0;
            timer_pulse <= '0;
        end else begin
            timer_pulse <= wrap;
            flag        <= (flag & ~{NTIMERS{flag_clear}}) | flag_set;
        end
    end

`ifdef OPL_TIMER_POLL_FORCE_EN
    logic [31:0] rd_count;
    logic [31:0] window;
    logic        poll_fire;

    assign poll_fire = status_rd && !ctrl_wr && (rd_count == 32'(POLL_COUNT - 1));
    assign poll_set  = poll_fire ? ~mask : '0;

    // Poll detector: counts status reads that arrive within a tick window of each other
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count <= 32'd0;
            window   <= 32'd0;
        end else if (ctrl_wr) begin
            rd_count <= 32'd0;
            window   <= 32'd0;
        end else if (status_rd) begin
            window <= 32'd0;
            if (rd_count != 32'(POLL_COUNT)) begin
                rd_count <= rd_count + 32'd1;
            end
        end else if (ce_1us) begin
            if (window == 32'(POLL_WINDOW - 1)) begin
                window   <= 32'd0;
                rd_count <= 32'd0;
            end else begin
                window <= window + 32'd1;
            end
        end
    end
`else
    logic unused_poll;

    assign poll_set    = '0;
    assign unused_poll = ^{status_rd, POLL_COUNT[0], POLL_WINDOW[0]};
`endif

    // Spread flags into fixed status positions; absent timers read zero
    always_comb begin
        flag3 = 3'd0;
        for (int i = 0; i < NTIMERS; i++) begin
            flag3[i] = flag[i];
        end
    end

    assign status = {|flag, flag3[0], flag3[1], flag3[2], 4'd0};
    assign irq_n  = ~|flag;

endmodule

// File: tb/tb_opl_timer_bank.sv
// tb/tb_opl_timer_bank.sv - directed and randomized checks of opl_timer_bank against a tick-count model
`timescale 1ns/1ps
module tb_opl_timer_bank;
    localparam int NT = 2;
`ifdef OPL_TIMER_POLL_FORCE_EN
    localparam logic [7:0] POLL_EXP = 8'hE0;
`else
    localparam logic [7:0] POLL_EXP = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce_1us = 1'b0;
    logic          wr = 1'b0;
    logic [8:0]    wr_index = 9'd0;
    logic [7:0]    wr_data = 8'd0;
    logic          status_rd = 1'b0;
    logic [7:0]    status;
    logic          irq_n;
    logic [NT-1:0] timer_pulse;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    opl_timer_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce_1us     (ce_1us),
        .wr         (wr),
        .wr_index   (wr_index),
        .wr_data    (wr_data),
        .status_rd  (status_rd),
        .status     (status),
        .irq_n      (irq_n),
        .timer_pulse(timer_pulse)
    );

    always #5 clk = ~clk;

    // Model: ticks elapsed since the current period began, and the preset that period started from
    int            m_ticks [NT];
    int            m_base  [NT];
    logic [7:0]    m_preset[NT];
    logic [NT-1:0] m_start, m_mask, m_flag, m_pulse, m_wrap, m_set;
    logic          m_cw, m_clr;
    int            m_rd, m_win;

    function automatic int period(input int i, input int b);
        return (80 << (2 * i)) * (256 - b);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) begin
                m_ticks[i] = 0;
                m_base[i] = 0;
                m_preset[i] = 8'd0;
            end
            m_start = '0; m_mask = '0; m_flag = '0; m_pulse = '0;
            m_rd = 0; m_win = 0;
        end else begin
            m_cw  = wr && (wr_index == 9'd4);
            m_clr = m_cw && wr_data[7];
            for (int i = 0; i < NT; i++) begin
                m_wrap[i] = m_start[i] && ce_1us && (m_ticks[i] + 1 == period(i, m_base[i]));
            end
            m_set = m_wrap & ~m_mask;
`ifdef OPL_TIMER_POLL_FORCE_EN
            if (m_cw) begin
                m_rd = 0; m_win = 0;
            end else if (status_rd) begin
                if (m_rd == 20) m_set = m_set | ~m_mask;
                if (m_rd < 21) m_rd++;
                m_win = 0;
            end else if (ce_1us) begin
                m_win++;
                if (m_win == 100000) begin m_win = 0; m_rd = 0; end
            end
`endif
            for (int i = 0; i < NT; i++) begin
                if (!m_start[i]) begin
                    m_ticks[i] = 0;
                    m_base[i] = m_preset[i];
                end else if (ce_1us) begin
                    if (m_wrap[i]) begin
                        m_ticks[i] = 0;
                        m_base[i] = m_preset[i];
                    end else begin
                        m_ticks[i]++;
                    end
                end
            end
            m_pulse = m_wrap;
            m_flag  = (m_flag & ~{NT{m_clr}}) | m_set;
            for (int i = 0; i < NT; i++) begin
                if (wr && (wr_index == 9'(2 + i))) m_preset[i] = wr_data;
                if (m_cw && !wr_data[7]) begin
                    m_mask[i]  = wr_data[6 - i];
                    m_start[i] = wr_data[i];
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("model status", int'(status), int'({|m_flag, m_flag[0], m_flag[1], 5'd0}));
            check("model irq_n", int'(irq_n), int'(!(|m_flag)));
            check("model timer_pulse", int'(timer_pulse), int'(m_pulse));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ce_1us = 1'b0; wr = 1'b0; status_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr_reg(input logic [8:0] idx, input logic [7:0] d);
        @(negedge clk);
        wr = 1'b1; wr_index = idx; wr_data = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic count_to_pulse(input int idx, input int limit, output int n);
        n = -1;
        ce_1us = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (timer_pulse[idx]) begin
                n = k;
                break;
            end
        end
        ce_1us = 1'b0;
    endtask

    initial begin
        int n;
        do_reset();
        checking = 1'b1;
        check("reset status", int'(status), 8'h00);
        check("reset irq_n", int'(irq_n), 1);
        check("reset pulse", int'(timer_pulse), 0);

        wr_reg(9'd2, 8'hFF);
        wr_reg(9'd4, 8'h01);
        count_to_pulse(0, 200, n);
        check("t0 first period", n, 80);
        check("t0 status", int'(status), 8'hC0);
        check("t0 irq_n", int'(irq_n), 0);
        count_to_pulse(0, 200, n);
        check("t0 second period", n, 80);

        do_reset();
        wr_reg(9'd3, 8'hFE);
        wr_reg(9'd4, 8'h02);
        count_to_pulse(1, 1000, n);
        check("t1 first period", n, 640);
        check("t1 status", int'(status), 8'hA0);

        do_reset();
        wr_reg(9'd2, 8'hFF);
        wr_reg(9'd4, 8'h41);
        count_to_pulse(0, 200, n);
        check("masked period", n, 80);
        check("masked status", int'(status), 8'h00);
        check("masked irq_n", int'(irq_n), 1);

        do_reset();
        wr_reg(9'd2, 8'hFF);
        wr_reg(9'd4, 8'h01);
        ce_1us = 1'b1;
        repeat (79) @(negedge clk);
        wr = 1'b1; wr_index = 9'd4; wr_data = 8'h80;
        @(negedge clk);
        wr = 1'b0; ce_1us = 1'b0;
        check("clear race pulse", int'(timer_pulse[0]), 1);
        check("clear race status", int'(status), 8'hC0);
        wr_reg(9'd4, 8'h80);
        check("clear status", int'(status), 8'h00);
        check("clear irq_n", int'(irq_n), 1);
        count_to_pulse(0, 200, n);
        check("period after clear", n, 80);

        do_reset();
        for (int r = 1; r <= 21; r++) begin
            @(negedge clk);
            status_rd = 1'b1;
            @(negedge clk);
            status_rd = 1'b0;
            if (r == 20) check("poll after 20 reads", int'(status), 8'h00);
            if (r == 21) check("poll after 21 reads", int'(status), int'(POLL_EXP));
            ce_1us = 1'b1;
            repeat (10) @(negedge clk);
            ce_1us = 1'b0;
        end

        do_reset();
        wr_reg(9'd2, 8'hF0);
        wr_reg(9'd4, 8'h01);
        ce_1us = 1'b1;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid reset status", int'(status), 8'h00);
        check("mid reset pulse", int'(timer_pulse), 0);
        count_to_pulse(0, 100, n);
        check("no pulse after reset", n, -1);
        wr_reg(9'd4, 8'h01);
        count_to_pulse(0, 21000, n);
        check("restart from preset 0", n, 20480);

        do_reset();
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            ce_1us    = ($urandom_range(0, 1) == 1);
            status_rd = ($urandom_range(0, 7) == 0);
            wr        = ($urandom_range(0, 15) == 0);
            rst_n     = ($urandom_range(0, 4999) != 0);
            case ($urandom_range(0, 4))
                0: begin wr_index = 9'd2; wr_data = 8'($urandom_range(248, 255)); end
                1: begin wr_index = 9'd3; wr_data = 8'($urandom_range(240, 255)); end
                2: begin wr_index = 9'd4; wr_data = 8'($urandom); end
                3: begin wr_index = 9'd4; wr_data = 8'h03 | (8'($urandom) & 8'h60); end
                default: begin wr_index = 9'($urandom); wr_data = 8'($urandom); end
            endcase
        end
        @(negedge clk);
        rst_n = 1'b1; wr = 1'b0; status_rd = 1'b0; ce_1us = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
